// File: rtl/parity_check_controller_if.sv
// Requester/result bundle for parity_check_controller.
// PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN adds the sticky irq/irq_clr pair.
interface parity_check_controller_if #(
    parameter int CNT_W = 8
);
    logic             req0;
    logic [3:0]       data0;
    logic             par0;
    logic             gnt0;
    logic             req1;
    logic [3:0]       data1;
    logic             par1;
    logic             gnt1;
    logic             cnt_clr;
    logic             res_valid;
    logic             res_id;
    logic             res_err;
    logic [CNT_W-1:0] err_cnt0;
    logic [CNT_W-1:0] err_cnt1;
    logic             busy;
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
    logic             irq;
    logic             irq_clr;
`endif

    modport master (
        output req0, data0, par0, req1, data1, par1, cnt_clr,
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
        output irq_clr,
        input  irq,
`endif
        input  gnt0, gnt1, res_valid, res_id, res_err, err_cnt0, err_cnt1, busy
    );

    modport slave (
        input  req0, data0, par0, req1, data1, par1, cnt_clr,
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
        input  irq_clr,
        output irq,
`endif
        output gnt0, gnt1, res_valid, res_id, res_err, err_cnt0, err_cnt1, busy
    );
endinterface

// File: rtl/parity_check_controller.sv
// Two-requester round-robin odd-parity checker with saturating error counters.
// PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN adds a sticky error interrupt.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and captures the winner's word
// CHECK  | winner's gnt high for one cycle, parity evaluated
// REPORT | res_valid strobe; error counter / irq updated at the end of this cycle
module parity_check_controller #(
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    parity_check_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t           state;
    logic             last;
    logic             win_id;
    logic [3:0]       data_q;
    logic             par_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             res_err_q;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             pick1;
    logic             err;
    logic             report_err;

    // Simultaneous requests go to whoever was not served last.
    always_comb begin
        pick1 = 1'b0;
        if (bus.req0 && bus.req1)
            pick1 = ~last;
        else
            pick1 = bus.req1;
    end

    always_comb err = ~(^data_q) ^ par_q;

    always_comb report_err = (state == REPORT) && res_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            win_id      <= 1'b0;
            data_q      <= '0;
            par_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state  <= CHECK;
                        win_id <= pick1;
                        last   <= pick1;
                        data_q <= pick1 ? bus.data1 : bus.data0;
                        par_q  <= pick1 ? bus.par1 : bus.par0;
                        gnt0_q <= ~pick1;
                        gnt1_q <= pick1;
                    end
                end
                CHECK: begin
                    state       <= REPORT;
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    res_valid_q <= 1'b1;
                    res_id_q    <= win_id;
                    res_err_q   <= err;
                end
                REPORT: begin
                    state       <= IDLE;
                    res_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Clear beats a coincident increment; counters stick at all-ones.
            if (bus.cnt_clr) begin
                cnt0 <= '0;
                cnt1 <= '0;
            end else if (report_err) begin
                if (!res_id_q && (cnt0 != '1))
                    cnt0 <= cnt0 + 1'b1;
                if (res_id_q && (cnt1 != '1))
                    cnt1 <= cnt1 + 1'b1;
            end
        end
    end

`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst)
            irq_q <= 1'b0;
        else if (report_err)
            irq_q <= 1'b1;
        else if (bus.irq_clr)
            irq_q <= 1'b0;
    end

    assign bus.irq = irq_q;
`endif

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;
    assign bus.err_cnt0  = cnt0;
    assign bus.err_cnt1  = cnt1;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_parity_check_controller.sv
// Directed bench for parity_check_controller; inputs change and outputs are sampled on negedge.
module tb_parity_check_controller;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    parity_check_controller_if #(.CNT_W(CNT_W)) bus ();

    parity_check_controller #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Starts just after a negedge with the DUT idle; ends the same way.
    task automatic send_word(input logic id, input logic [3:0] d, input logic p);
        if (id) begin
            bus.req1 = 1'b1; bus.data1 = d; bus.par1 = p;
        end else begin
            bus.req0 = 1'b1; bus.data0 = d; bus.par0 = p;
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", bus.gnt1, bus.gnt0); end
        n_checks++; if (bus.res_valid !== 1'b0 || bus.res_id !== 1'b0 || bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res: got v%b id%b err%b expected all 0", bus.res_valid, bus.res_id, bus.res_err); end
        n_checks++; if (bus.err_cnt0 !== 8'd0 || bus.err_cnt1 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.err_cnt0, bus.err_cnt1); end
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single0_ok();
        bus.req0 = 1'b1; bus.data0 = 4'b1010; bus.par0 = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL s0_gnt: got %b%b expected 01", bus.gnt1, bus.gnt0); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL s0_busy: got %b expected 1", bus.busy); end
        bus.req0 = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 || bus.res_err !== 1'b0) begin n_fail++; $display("FAIL s0_res: got v%b id%b err%b expected v1 id0 err0", bus.res_valid, bus.res_id, bus.res_err); end
        n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL s0_gnt_width: got %b expected 0", bus.gnt0); end
        @(negedge clk);
        n_checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL s0_done: got v%b busy%b expected 0 0", bus.res_valid, bus.busy); end
        n_checks++; if (bus.err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL s0_cnt: got %0d expected 0", bus.err_cnt0); end
    endtask

    task automatic test_single1_err();
        bus.req1 = 1'b1; bus.data1 = 4'b0111; bus.par1 = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL s1_gnt: got %b%b expected 10", bus.gnt1, bus.gnt0); end
        bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 || bus.res_err !== 1'b1) begin n_fail++; $display("FAIL s1_res: got v%b id%b err%b expected v1 id1 err1", bus.res_valid, bus.res_id, bus.res_err); end
        n_checks++; if (bus.err_cnt1 !== 8'd0) begin n_fail++; $display("FAIL s1_cnt_before: got %0d expected 0", bus.err_cnt1); end
        @(negedge clk);
        n_checks++; if (bus.err_cnt1 !== 8'd1 || bus.err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL s1_cnt_after: got %0d/%0d expected 0/1", bus.err_cnt0, bus.err_cnt1); end
        n_checks++; if (bus.res_id !== 1'b1 || bus.res_err !== 1'b1) begin n_fail++; $display("FAIL s1_hold: got id%b err%b expected id1 err1", bus.res_id, bus.res_err); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.data0 = 4'b1010; bus.par0 = 1'b1;
        bus.req1 = 1'b1; bus.data1 = 4'b1010; bus.par1 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt0 !== ((k == 1) || (k == 7)) || bus.gnt1 !== ((k == 4) || (k == 10))) begin
                n_fail++; $display("FAIL rr_gnt cycle %0d: got %b%b", k, bus.gnt1, bus.gnt0);
            end
            if ((k % 3) == 2) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== ((k == 5) || (k == 11))) begin
                    n_fail++; $display("FAIL rr_res cycle %0d: got v%b id%b", k, bus.res_valid, bus.res_id);
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        send_word(1'b1, 4'b0000, 1'b0);
        n_checks++; if (bus.err_cnt1 !== 8'd1) begin n_fail++; $display("FAIL rm_cnt_pre: got %0d expected 1", bus.err_cnt1); end
        bus.req0 = 1'b1; bus.data0 = 4'b0000; bus.par0 = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.gnt0 !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rm_check: got gnt0 %b busy %b expected 1 1", bus.gnt0, bus.busy); end
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rm_abort: got busy%b v%b gnt0%b expected 0 0 0", bus.busy, bus.res_valid, bus.gnt0); end
        n_checks++; if (bus.err_cnt0 !== 8'd0 || bus.err_cnt1 !== 8'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d/%0d expected 0/0", bus.err_cnt0, bus.err_cnt1); end
        @(negedge clk);
        n_checks++; if (bus.res_valid !== 1'b0 || bus.err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL rm_after: got v%b cnt0 %0d expected 0 0", bus.res_valid, bus.err_cnt0); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 300; i++) begin
            send_word(1'b0, 4'b0000, 1'b0);
            if (i == 254 || i == 255) begin
                n_checks++;
                if (bus.err_cnt0 !== i[7:0]) begin n_fail++; $display("FAIL sat_count word %0d: got %0d expected %0d", i, bus.err_cnt0, i); end
            end
        end
        n_checks++; if (bus.err_cnt0 !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", bus.err_cnt0); end
        n_checks++; if (bus.err_cnt1 !== 8'd0) begin n_fail++; $display("FAIL sat_other: got %0d expected 0", bus.err_cnt1); end
        bus.req0 = 1'b1; bus.data0 = 4'b0000; bus.par0 = 1'b0;
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b1) begin n_fail++; $display("FAIL clr_report: got v%b err%b expected 1 1", bus.res_valid, bus.res_err); end
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        n_checks++; if (bus.err_cnt0 !== 8'd0) begin n_fail++; $display("FAIL clr_priority: got %0d expected 0", bus.err_cnt0); end
        send_word(1'b0, 4'b1110, 1'b1);
        n_checks++; if (bus.err_cnt0 !== 8'd1) begin n_fail++; $display("FAIL clr_recount: got %0d expected 1", bus.err_cnt0); end
    endtask

`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
    task automatic test_irq();
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_pending: got %b expected 1", bus.irq); end
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear0: got %b expected 0", bus.irq); end
        bus.req1 = 1'b1; bus.data1 = 4'b0011; bus.par1 = 1'b0;
        @(negedge clk);
        bus.req1 = 1'b0;
        @(negedge clk);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b expected 1", bus.irq); end
        @(negedge clk);
        bus.irq_clr = 1'b0;
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", bus.irq); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.req0    = 1'b0; bus.data0 = 4'd0; bus.par0 = 1'b0;
        bus.req1    = 1'b0; bus.data1 = 4'd0; bus.par1 = 1'b0;
        bus.cnt_clr = 1'b0;
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single0_ok();
        test_single1_err();
        test_round_robin();
        test_reset_mid();
        test_saturation();
`ifdef PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_check_controller.md
PARITY_CHECK_CONTROLLER -- requirements
Module: parity_check_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of each per-requester error counter.
REQ-002 SHALL have port CLK, input, 1, the single clock.
REQ-003 SHALL have port RST, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port REQ0, input, 1, requester 0 check request.
REQ-005 SHALL have port DATA0, input, 4, requester 0 data nibble.
REQ-006 SHALL have port PAR0, input, 1, requester 0 odd-parity bit.
REQ-007 SHALL have port GNT0, output, 1, requester 0 word-captured pulse.
REQ-008 SHALL have ports REQ1/DATA1/PAR1/GNT1, identical to REQ-004..REQ-007 for requester 1.
REQ-009 SHALL have port CNT_CLR, input, 1, clears both error counters.
REQ-010 SHALL have port RES_VALID, output, 1, one-cycle result strobe.
REQ-011 SHALL have port RES_ID, output, 1, requester index of the result.
REQ-012 SHALL have port RES_ERR, output, 1, 1 = parity error.
REQ-013 SHALL have ports ERR_CNT0 and ERR_CNT1, output, CNT_W each, per-requester error counts.
REQ-014 SHALL have port BUSY, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM:
- IDLE -> CHECK when REQ0 or REQ1 is sampled high.
- CHECK -> REPORT unconditionally.
- REPORT -> IDLE unconditionally.
REQ-016 SHALL, on the IDLE->CHECK transition, register the winner's DATA/PAR and index, and drive that requester's GNT high for exactly the one CHECK cycle.
REQ-017 SHALL arbitrate round-robin: a lone request wins; on simultaneous requests, the requester not served last wins.
REQ-018 SHALL set the last-served pointer at reset so that requester 0 wins the first simultaneous contest.
REQ-019 SHALL compute the odd-parity bit OP = NOT(D3^D2^D1^D0) of the captured nibble, and set error = OP ^ P (an even total count of ones across the five bits is an error).
REQ-020 SHALL, in REPORT, drive RES_VALID=1, RES_ID=winner and RES_ERR=error for exactly one cycle; RES_ID/RES_ERR SHALL hold their last values otherwise.
REQ-021 SHALL give a latency of: REQ sampled in cycle N, GNT in N+1, RES_VALID in N+2; the earliest next sample is N+3, and the earliest next GNT is N+4.
REQ-022 SHALL require each requester to hold REQ/DATA/PAR stable until GNT and to drop REQ the cycle after GNT; a REQ still high in IDLE is a new request.
REQ-023 SHALL increment the winner's error counter in the REPORT cycle when error=1, saturating at all-ones (no wrap).
REQ-024 SHALL give CNT_CLR priority over a coincident increment: both counters go to 0 and that error is not counted.
REQ-025 SHALL leave request inputs without effect while not in IDLE.

Reset
REQ-026 SHALL, with RST high at a clock edge, force state=IDLE, GNT0=GNT1=0, RES_VALID=0, RES_ID=0, RES_ERR=0, ERR_CNT0=ERR_CNT1=0, BUSY=0, and last-served=1.
REQ-027 SHALL, on reset asserted in CHECK or REPORT, abandon the in-flight check: no RES_VALID and no counter update.

Configuration
REQ-028 SHALL, with macro PARITY_CHECK_CONTROLLER_STICKY_IRQ_EN defined, add:
- output IRQ, set in any REPORT cycle with error=1;
- input IRQ_CLR, which clears IRQ;
- set wins over a coincident IRQ_CLR;
- IRQ resets to 0.
REQ-029 SHALL, with the macro undefined, omit IRQ and IRQ_CLR and leave all other behaviour unchanged.

Verification
REQ-030 SHALL cover: REQ0 with DATA0=1010, PAR0=1 -> GNT0 at N+1; RES_VALID=1, RES_ID=0, RES_ERR=0 at N+2; ERR_CNT0=0.
REQ-031 SHALL cover: REQ1 with DATA1=0111, PAR1=1 -> RES_ERR=1, RES_ID=1; ERR_CNT1 0->1.
REQ-032 SHALL cover: REQ0 and REQ1 held continuously after reset -> grant order 0,1,0,1, with GNTs 3 cycles apart.
REQ-033 SHALL cover: CNT_W=8 with 300 error words from requester 0 -> ERR_CNT0 saturates at 255; then CNT_CLR during an error REPORT -> ERR_CNT0=0.
REQ-034 SHALL cover: RST pulsed in the CHECK cycle -> no RES_VALID, counters 0, BUSY=0 next cycle.
REQ-035 SHALL cover, with the macro defined: an error report with IRQ_CLR high in the same cycle -> IRQ=1; IRQ_CLR alone next cycle -> IRQ=0.
